zacore_fetch_queue: RTL and testbench
=====================================

// Module: zacore_fetch_queue
// PURPOSE
//   Parametrised successor to the single-PC fetch stage. Generates sequential instruction
//   fetches and buffers up to QUEUE_DEPTH {pc, inst} pairs in a FIFO ahead of decode.
//   Supports redirect from execute (branch/jump taken) and invalidate (replay from oldest
//   unconsumed PC). Sits between the instruction memory port and zacore decode.
// PARAMETERS
//   RESET_PC     32'h0000_0000  first fetch address after reset; bits [1:0] must be 0
//   QUEUE_DEPTH  4              FIFO entries; power of two, >= 2
// PORTS
//   i_clk             in   1   clock, all state updates on posedge
//   i_rst             in   1   reset, synchronous, active-high
//   o_fetch_req       out  1   fetch request valid
//   i_fetch_ack       in   1   memory accepted o_fetch_addr and returns data this cycle
//   o_fetch_addr      out  32  fetch address, word aligned
//   i_inst_read       in   32  instruction data, valid only when o_fetch_req & i_fetch_ack
//   o_valid           out  1   queue head valid to decode
//   o_inst            out  32  queue head instruction
//   o_pc              out  32  queue head PC
//   i_decode_ready    in   1   decode consumes head when o_valid & i_decode_ready (pop)
//   i_redirect_valid  in   1   execute redirect strobe, one cycle
//   i_redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//   i_invalidate      in   1   flush queue and replay from oldest unconsumed PC
//   o_queue_count     out  $clog2(QUEUE_DEPTH+1)  current occupancy
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, count=0, rd/wr ptr=0. While i_rst high: o_fetch_req=0,
//     o_valid=0, o_fetch_addr=RESET_PC, o_queue_count=0. Reset mid-transfer drops the ack.
//   o_fetch_req = ~i_rst & (count < QUEUE_DEPTH); derived from registered state only
//     (no combinational path from i_decode_ready, i_redirect_valid or i_invalidate).
//   o_fetch_addr = fetch_pc (registered). Memory samples the address only in ack cycle;
//     address may change while req high and unacked; request held until ack.
//   Push: o_fetch_req & i_fetch_ack & ~i_redirect_valid & ~i_invalidate -> write
//     {fetch_pc, i_inst_read} at wr_ptr; fetch_pc <= fetch_pc+4 (wraps 32'hFFFF_FFFC->0).
//   Latency: ack in cycle N -> entry on o_valid/o_inst/o_pc in cycle N+1. No bypass.
//   Pop: o_valid & i_decode_ready & ~i_redirect_valid & ~i_invalidate; rd_ptr advances.
//   Push+pop same cycle: count unchanged. Full: no req, so no push; pop frees a slot and
//     req asserts next cycle. Empty: o_valid=0, pop impossible. Pointers wrap mod DEPTH.
//   Redirect (priority 1): queue flushed (count=0, ptrs=0), fetch_pc <= {i_redirect_pc[31:2],2'b00};
//     same-cycle ack data and pop are discarded; o_valid=0 next cycle.
//   Invalidate (priority 2, ignored if redirect same cycle): queue flushed, ack data and pop
//     discarded; fetch_pc <= head entry PC if count>0, else fetch_pc unchanged.
//   o_inst/o_pc hold head entry contents; value undefined-but-stable when o_valid=0.
//   o_queue_count = count (registered), 0..QUEUE_DEPTH.
// TESTING
//   Reset, mem acks every cycle, decode ready -> addrs 0,4,8,..; o_pc==addr 1 cycle after ack.
//   Decode ready=0, acks continuous, DEPTH=4 -> 4 pushes, count=4, o_fetch_req=0; ready=1 one
//     cycle -> pop pc 0, req reasserts next cycle with addr 16.
//   Redirect to 32'h0000_1003 in same cycle as ack of 8 -> ack data dropped, queue empty,
//     next o_fetch_addr=32'h0000_1000, first o_pc=32'h1000.
//   Queue holds pcs 4,8,12, invalidate -> count=0, next fetch addr=4; redirect+invalidate
//     same cycle -> redirect target wins.
//   Ack withheld 3 cycles -> o_fetch_req and o_fetch_addr stable, no push; RESET_PC=32'hFFFF_FFF8
//     -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   Assert i_rst while count=3 and ack high -> count=0, o_valid=0, addr=RESET_PC after reset.

Source files
------------

// File: rtl/zacore_fetch_queue.sv
// Sequential instruction fetch with a small {pc, inst} FIFO ahead of decode.
// Supports execute redirect and replay-from-oldest invalidate.
module zacore_fetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    output logic                               o_fetch_req,
    input  logic                               i_fetch_ack,
    output logic [31:0]                        o_fetch_addr,
    input  logic [31:0]                        i_inst_read,
    output logic                               o_valid,
    output logic [31:0]                        o_inst,
    output logic [31:0]                        o_pc,
    input  logic                               i_decode_ready,
    input  logic                               i_redirect_valid,
    input  logic [31:0]                        i_redirect_pc,
    input  logic                               i_invalidate,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_queue_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] pc_mem   [QUEUE_DEPTH];
    logic [31:0] inst_mem [QUEUE_DEPTH];

    logic fetch_req;
    logic head_valid;
    logic flush;
    logic push;
    logic pop;

    // Low address bits of the redirect target are discarded by design.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    assign fetch_req  = ~i_rst & (count_q < DEPTH_CNT);
    assign head_valid = ~i_rst & (count_q != '0);
    assign flush      = i_redirect_valid | i_invalidate;
    assign push       = fetch_req & i_fetch_ack & ~flush;
    assign pop        = head_valid & i_decode_ready & ~flush;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (i_redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
        end else if (i_invalidate) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            // Replay from the oldest entry decode has not yet consumed.
            if (count_q != '0) begin
                fetch_pc_d = pc_mem[rd_ptr_q];
            end
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= i_inst_read;
        end
    end

    assign o_fetch_req   = fetch_req;
    assign o_fetch_addr  = i_rst ? RESET_PC : fetch_pc_q;
    assign o_valid       = head_valid;
    assign o_inst        = inst_mem[rd_ptr_q];
    assign o_pc          = pc_mem[rd_ptr_q];
    assign o_queue_count = i_rst ? '0 : count_q;

endmodule

// File: tb/tb_zacore_fetch_queue.sv
// Directed bench for zacore_fetch_queue: streaming, full, redirect, invalidate,
// stall, address wrap and reset-during-transfer scenarios.
module tb_zacore_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        fetch_ack;
    logic [31:0] fetch_addr;
    logic [31:0] inst_read;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        decode_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        invalidate;
    logic [2:0]  queue_count;

    logic        w_rst;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_addr;
    logic [31:0] w_inst_read;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [2:0]  w_count;

    int checks;
    int errors;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign inst_read   = inst_of(fetch_addr);
    assign w_inst_read = inst_of(w_addr);

    zacore_fetch_queue #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_fetch_req      (fetch_req),
        .i_fetch_ack      (fetch_ack),
        .o_fetch_addr     (fetch_addr),
        .i_inst_read      (inst_read),
        .o_valid          (valid),
        .o_inst           (inst),
        .o_pc             (pc),
        .i_decode_ready   (decode_ready),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_invalidate     (invalidate),
        .o_queue_count    (queue_count)
    );

    zacore_fetch_queue #(
        .RESET_PC    (32'hFFFF_FFF8),
        .QUEUE_DEPTH (4)
    ) dut_w (
        .i_clk            (clk),
        .i_rst            (w_rst),
        .o_fetch_req      (w_req),
        .i_fetch_ack      (w_ack),
        .o_fetch_addr     (w_addr),
        .i_inst_read      (w_inst_read),
        .o_valid          (w_valid),
        .o_inst           (w_inst),
        .o_pc             (w_pc),
        .i_decode_ready   (1'b1),
        .i_redirect_valid (1'b0),
        .i_redirect_pc    (32'h0),
        .i_invalidate     (1'b0),
        .o_queue_count    (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_ack      = 1'b0;
        decode_ready   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        invalidate     = 1'b0;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", fetch_req); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 00000000", fetch_addr); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", queue_count); end
        rst = 1'b0;
        #1;
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL rst_release_req got %b want 1", fetch_req); end
    endtask

    task automatic test_stream();
        fetch_ack    = 1'b1;
        decode_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (fetch_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr got %h want %h", fetch_addr, 32'(4 * i)); end
            tick();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_valid got %b want 1", valid); end
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc got %h want %h", pc, 32'(4 * i)); end
            checks++; if (inst !== inst_of(32'(4 * i))) begin errors++; $display("FAIL stream_inst got %h want %h", inst, inst_of(32'(4 * i))); end
            checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL stream_count got %0d want 1", queue_count); end
        end
        fetch_ack = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b want 0", valid); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL stream_drain_count got %0d want 0", queue_count); end
    endtask

    task automatic test_full();
        do_reset();
        fetch_ack    = 1'b1;
        decode_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", queue_count); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL full_req got %b want 0", fetch_req); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL full_head got %h want 00000000", pc); end
        decode_ready = 1'b1;
        tick();
        checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", queue_count); end
        checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL full_rereq got %b want 1", fetch_req); end
        checks++; if (fetch_addr !== 32'h10) begin errors++; $display("FAIL full_addr got %h want 00000010", fetch_addr); end
        decode_ready = 1'b0;
        tick();
        checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL full_refill got %0d want 4", queue_count); end
        fetch_ack    = 1'b0;
        decode_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (pc !== 32'(4 + 4 * j)) begin errors++; $display("FAIL full_drain_pc got %h want %h", pc, 32'(4 + 4 * j)); end
            checks++; if (inst !== inst_of(32'(4 + 4 * j))) begin errors++; $display("FAIL full_drain_inst got %h want %h", inst, inst_of(32'(4 + 4 * j))); end
            tick();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", valid); end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_ack = 1'b1;
        tick();
        tick();
        checks++; if (fetch_addr !== 32'h8) begin errors++; $display("FAIL redir_pre_addr got %h want 00000008", fetch_addr); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        decode_ready   = 1'b1;
        tick();
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL redir_count got %0d want 0", queue_count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", valid); end
        checks++; if (fetch_addr !== 32'h0000_1000) begin errors++; $display("FAIL redir_addr got %h want 00001000", fetch_addr); end
        redirect_valid = 1'b0;
        tick();
        checks++; if (pc !== 32'h0000_1000) begin errors++; $display("FAIL redir_pc got %h want 00001000", pc); end
        checks++; if (inst !== inst_of(32'h0000_1000)) begin errors++; $display("FAIL redir_inst got %h want %h", inst, inst_of(32'h0000_1000)); end
        fetch_ack = 1'b0;
        tick();
    endtask

    task automatic test_invalidate();
        do_reset();
        fetch_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        fetch_ack    = 1'b0;
        decode_ready = 1'b1;
        tick();
        checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL inv_pre_count got %0d want 3", queue_count); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL inv_pre_head got %h want 00000004", pc); end
        invalidate = 1'b1;
        fetch_ack  = 1'b1;
        tick();
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL inv_count got %0d want 0", queue_count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL inv_valid got %b want 0", valid); end
        checks++; if (fetch_addr !== 32'h4) begin errors++; $display("FAIL inv_addr got %h want 00000004", fetch_addr); end
        invalidate   = 1'b0;
        decode_ready = 1'b0;
        tick();
        tick();
        checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL inv_refill got %0d want 2", queue_count); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        invalidate     = 1'b1;
        tick();
        checks++; if (fetch_addr !== 32'h0000_2000) begin errors++; $display("FAIL inv_redir_addr got %h want 00002000", fetch_addr); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL inv_redir_count got %0d want 0", queue_count); end
        redirect_valid = 1'b0;
        invalidate     = 1'b0;
        fetch_ack      = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL stall_req got %b want 1", fetch_req); end
            checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL stall_addr got %h want 00000000", fetch_addr); end
            checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL stall_count got %0d want 0", queue_count); end
        end
        fetch_ack = 1'b1;
        tick();
        checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL stall_push got %0d want 1", queue_count); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL stall_pc got %h want 00000000", pc); end
        fetch_ack = 1'b0;
    endtask

    task automatic test_wrap();
        checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_rst_addr got %h want fffffff8", w_addr); end
        checks++; if (w_req !== 1'b0) begin errors++; $display("FAIL wrap_rst_req got %b want 0", w_req); end
        w_rst = 1'b0;
        w_ack = 1'b1;
        #1;
        checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0 got %h want fffffff8", w_addr); end
        tick();
        checks++; if (w_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0 got %h want fffffff8", w_pc); end
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1 got %h want fffffffc", w_addr); end
        tick();
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1 got %h want fffffffc", w_pc); end
        checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr2 got %h want 00000000", w_addr); end
        tick();
        checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc2 got %h want 00000000", w_pc); end
        checks++; if (w_inst !== inst_of(32'h0)) begin errors++; $display("FAIL wrap_inst2 got %h want %h", w_inst, inst_of(32'h0)); end
        checks++; if (w_valid !== 1'b1 || w_count !== 3'd1) begin errors++; $display("FAIL wrap_occ got %b/%0d want 1/1", w_valid, w_count); end
        w_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (queue_count !== 3'd3) begin errors++; $display("FAIL rmid_pre got %0d want 3", queue_count); end
        rst = 1'b1;
        tick();
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", queue_count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b want 0", fetch_req); end
        fetch_ack = 1'b0;
        rst       = 1'b0;
        #1;
        checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h want 00000000", fetch_addr); end
        tick();
        checks++; if (queue_count !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL rmid_after got %0d/%b want 0/0", queue_count, valid); end
        checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL rmid_after_addr got %h want 00000000", fetch_addr); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        fetch_ack      = 1'b0;
        decode_ready   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        invalidate     = 1'b0;
        w_rst          = 1'b1;
        w_ack          = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_invalidate();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
